data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter ADDR_BITS, default 12, byte-address width of the implemented storage (2^ADDR_BITS bytes, organised as 2^(ADDR_BITS-2) 32-bit words).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 mem_addrs  input  32  byte address from the CPU.
REQ-005 data_mem_OUT  input  32  CPU store data; the low byte or halfword is used for SB/SH.
REQ-006 mem_MODE  input  3  access size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU; 011/110/111 are invalid.
REQ-007 mem_WE  input  1  store strobe, sampled on the rising edge.
REQ-008 data_mem_IN  output  32  registered load data returned to the CPU.
REQ-009 fault  output  1  sticky store-fault flag.
REQ-010 fault_addrs  output  32  address of the first faulting store since the last clear.
REQ-011 fault_clr  input  1  synchronous clear of fault and fault_addrs.

Function
REQ-012 Byte order SHALL be little-endian: lane k = word bits [8k+7:8k], selected by mem_addrs[1:0]; word index = mem_addrs[ADDR_BITS-1:2].
REQ-013 A read SHALL occur every cycle, independent of mem_WE; data_mem_IN SHALL be registered, with one-cycle latency from the edge sampling mem_addrs/mem_MODE.
REQ-014 Load formatting: B sign-extends the selected byte; BU zero-extends it; H/HU sign-/zero-extend lane pair addr[1] (bits [15:0] or [31:16]); W returns the full word.
REQ-015 Reads that are misaligned (H/HU with addr[0]=1; W with addr[1:0]!=0), out of range (any of mem_addrs[31:ADDR_BITS] set), or use an invalid mode SHALL return 32'h0 and SHALL NOT set fault.
REQ-016 Store: with mem_WE=1 on an edge and the access valid, only the addressed lanes SHALL be written: SB one lane from data_mem_OUT[7:0]; SH lanes {2,3} or {0,1} from [15:0]; SW all lanes. Other lanes SHALL be unchanged.
REQ-017 Stores with mode BU/HU, or with any invalid mode, misalignment, or out-of-range address, SHALL write nothing and SHALL be store faults.
REQ-018 Read-during-write to the same word SHALL return the pre-write contents (read-first); the new value SHALL be visible from the following access.
REQ-019 On a store fault with fault=0: fault<=1 and fault_addrs<=mem_addrs. While fault=1, later faults SHALL NOT change fault_addrs.
REQ-020 fault_clr=1 SHALL clear fault and fault_addrs to 0 on the edge. If a store fault occurs on the same edge, set wins: fault=1 and fault_addrs=the new address.
REQ-021 Storage SHALL be inferable as block RAM: one word read port and one byte-lane-masked write port.

Reset
REQ-022 While reset=0: data_mem_IN=0, fault=0, fault_addrs=0, asynchronously and regardless of clk.
REQ-023 While reset=0, no store SHALL be performed; storage contents SHALL NOT be cleared by reset.
REQ-024 After reset deasserts, the first edge SHALL behave as a normal cycle. A store coinciding with the deasserting edge SHALL be performed only if reset=1 when that edge occurs.

Verification
REQ-025 SW 0x0000_0010 <- 0xDEADBEEF, then LW 0x10 -> data_mem_IN=0xDEADBEEF one cycle after address is presented.
REQ-026 After REQ-025: SB 0x13 <- 0x80; LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LW 0x10 -> 0x80ADBEEF.
REQ-027 SH 0x12 <- 0x1234; LH 0x12 -> 0x00001234; LHU 0x10 -> 0x0000BEEF; LW 0x10 -> 0x1234BEEF.
REQ-028 SW to 0x11 -> no write, fault=1, fault_addrs=0x11; then SW to 0x0000_1000 (ADDR_BITS=12) -> fault_addrs remains 0x11; fault_clr together with SH to 0x01 -> fault=1, fault_addrs=0x01.
REQ-029 SW 0x20 <- 0xA5A5A5A5 while reading 0x20 in the same cycle -> data_mem_IN shows the old value; the next LW 0x20 -> 0xA5A5A5A5.
REQ-030 Assert reset=0 mid-sequence, including asynchronously between edges -> outputs 0 immediately; SW issued during reset leaves memory unchanged; the data at 0x10 survives reset.

Source files
------------

// File: rtl/data_mem_responder.sv
// Byte-addressable data memory for a CPU load/store port: one word read per cycle with a
// registered result, a byte-lane masked write, and a sticky fault flag for bad stores.
module data_mem_responder #(
    parameter int ADDR_BITS = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addrs,
    input  logic [31:0] data_mem_OUT,
    input  logic [2:0]  mem_MODE,
    input  logic        mem_WE,
    output logic [31:0] data_mem_IN,
    output logic        fault,
    output logic [31:0] fault_addrs,
    input  logic        fault_clr
);

    localparam int WORDS = 2 ** (ADDR_BITS - 2);
    localparam logic [2:0] MODE_B  = 3'b000;
    localparam logic [2:0] MODE_H  = 3'b001;
    localparam logic [2:0] MODE_W  = 3'b010;
    localparam logic [2:0] MODE_BU = 3'b100;
    localparam logic [2:0] MODE_HU = 3'b101;

    logic [31:0]          mem [WORDS];
    logic [ADDR_BITS-3:0] word_idx;
    logic [1:0]           lane;
    logic                 in_range;
    logic                 aligned;
    logic                 mode_ok;
    logic                 load_ok;
    logic                 store_ok;
    logic                 store_fault;
    logic [3:0]           byte_en;
    logic [31:0]          wr_data;

    logic [31:0]          rd_word;
    logic [2:0]           rd_mode;
    logic [1:0]           rd_lane;
    logic                 rd_valid;
    logic [7:0]           rd_byte;
    logic [15:0]          rd_half;

    always_comb begin
        word_idx = mem_addrs[ADDR_BITS-1:2];
        lane     = mem_addrs[1:0];
        in_range = (mem_addrs >> ADDR_BITS) == 32'd0;
        mode_ok  = 1'b0;
        aligned  = 1'b0;
        case (mem_MODE)
            MODE_B, MODE_BU: begin
                mode_ok = 1'b1;
                aligned = 1'b1;
            end
            MODE_H, MODE_HU: begin
                mode_ok = 1'b1;
                aligned = ~lane[0];
            end
            MODE_W: begin
                mode_ok = 1'b1;
                aligned = (lane == 2'b00);
            end
            default: ;
        endcase
        load_ok     = in_range && mode_ok && aligned;
        // unsigned modes are load-only, so they fault as stores
        store_ok    = load_ok && (mem_MODE == MODE_B || mem_MODE == MODE_H || mem_MODE == MODE_W);
        store_fault = mem_WE && !store_ok;

        byte_en = 4'b0000;
        wr_data = data_mem_OUT;
        case (mem_MODE)
            MODE_B: begin
                byte_en = 4'b0001 << lane;
                wr_data = {4{data_mem_OUT[7:0]}};
            end
            MODE_H: begin
                byte_en = lane[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{data_mem_OUT[15:0]}};
            end
            MODE_W: byte_en = 4'b1111;
            default: ;
        endcase
    end

    // Storage: no reset, read-first, so it maps onto a byte-enabled block RAM.
    always_ff @(posedge clk) begin
        rd_word <= mem[word_idx];
        if (reset && mem_WE && store_ok) begin
            if (byte_en[0]) mem[word_idx][7:0]   <= wr_data[7:0];
            if (byte_en[1]) mem[word_idx][15:8]  <= wr_data[15:8];
            if (byte_en[2]) mem[word_idx][23:16] <= wr_data[23:16];
            if (byte_en[3]) mem[word_idx][31:24] <= wr_data[31:24];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_mode     <= MODE_B;
            rd_lane     <= 2'b00;
            rd_valid    <= 1'b0;
            fault       <= 1'b0;
            fault_addrs <= '0;
        end else begin
            rd_mode  <= mem_MODE;
            rd_lane  <= lane;
            rd_valid <= load_ok;
            if (store_fault && (!fault || fault_clr)) begin
                fault       <= 1'b1;
                fault_addrs <= mem_addrs;
            end else if (fault_clr) begin
                fault       <= 1'b0;
                fault_addrs <= '0;
            end
        end
    end

    // rd_valid is async-reset, which forces the load result to zero during reset
    always_comb begin
        rd_byte     = rd_word[{rd_lane, 3'b000} +: 8];
        rd_half     = rd_lane[1] ? rd_word[31:16] : rd_word[15:0];
        data_mem_IN = '0;
        if (rd_valid) begin
            case (rd_mode)
                MODE_B:  data_mem_IN = {{24{rd_byte[7]}}, rd_byte};
                MODE_BU: data_mem_IN = {24'b0, rd_byte};
                MODE_H:  data_mem_IN = {{16{rd_half[15]}}, rd_half};
                MODE_HU: data_mem_IN = {16'b0, rd_half};
                MODE_W:  data_mem_IN = rd_word;
                default: data_mem_IN = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios plus random traffic, checked against a
// byte-array reference model of the memory and fault flag.
module tb_data_mem_responder;

    logic        clk;
    logic        reset;
    logic [31:0] mem_addrs;
    logic [31:0] data_mem_OUT;
    logic [2:0]  mem_MODE;
    logic        mem_WE;
    logic [31:0] data_mem_IN;
    logic        fault;
    logic [31:0] fault_addrs;
    logic        fault_clr;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  mb [0:4095];
    logic        m_fault;
    logic [31:0] m_faddr;

    data_mem_responder #(.ADDR_BITS(12)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_addrs    (mem_addrs),
        .data_mem_OUT (data_mem_OUT),
        .mem_MODE     (mem_MODE),
        .mem_WE       (mem_WE),
        .data_mem_IN  (data_mem_IN),
        .fault        (fault),
        .fault_addrs  (fault_addrs),
        .fault_clr    (fault_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int access_size(input logic [2:0] m);
        case (m)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] m);
        logic [31:0] v;
        int sz;
        sz = access_size(m);
        if (sz == 0 || a >= 32'd4096) return 32'h0;
        if ((a % sz) != 0) return 32'h0;
        v = 32'h0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = mb[a + i];
        if (m == 3'd0) v = {{24{v[7]}}, v[7:0]};
        if (m == 3'd1) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    // One clocked access with reset high; the model is updated and all outputs are compared.
    task automatic step(input string tag, input logic [31:0] a, input logic [2:0] m,
                        input logic we, input logic [31:0] d, input logic clr);
        logic [31:0] exp_rd;
        logic        ok_store;
        int          sz;
        mem_addrs    = a;
        mem_MODE     = m;
        mem_WE       = we;
        data_mem_OUT = d;
        fault_clr    = clr;
        exp_rd = ref_load(a, m);
        @(posedge clk);
        #1;
        sz = (m == 3'd0) ? 1 : (m == 3'd1) ? 2 : (m == 3'd2) ? 4 : 0;
        ok_store = 1'b0;
        if (sz != 0 && a < 32'd4096) ok_store = ((a % sz) == 0);
        if (we && ok_store)
            for (int i = 0; i < sz; i++) mb[a + i] = d[8*i +: 8];
        if (we && !ok_store && (!m_fault || clr)) begin
            m_fault = 1'b1;
            m_faddr = a;
        end else if (clr) begin
            m_fault = 1'b0;
            m_faddr = 32'h0;
        end
        mem_WE    = 1'b0;
        fault_clr = 1'b0;
        check({tag, ".rd"}, data_mem_IN, exp_rd);
        check({tag, ".fault"}, {31'b0, fault}, {31'b0, m_fault});
        check({tag, ".faddr"}, fault_addrs, m_faddr);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, ".rd0"}, data_mem_IN, 32'h0);
        check({tag, ".fault0"}, {31'b0, fault}, 32'h0);
        check({tag, ".faddr0"}, fault_addrs, 32'h0);
    endtask

    initial begin
        logic [31:0] old_val;
        logic [31:0] saved;
        logic [31:0] ra;
        reset        = 1'b0;
        mem_addrs    = 32'h0;
        data_mem_OUT = 32'h0;
        mem_MODE     = 3'b010;
        mem_WE       = 1'b0;
        fault_clr    = 1'b0;
        m_fault      = 1'b0;
        m_faddr      = 32'h0;
        for (int i = 0; i < 4096; i++) mb[i] = 8'h00;

        #2;
        check_zero_outputs("reset_init");
        @(negedge clk);
        reset = 1'b1;

        for (int w = 0; w < 32; w++) step("prefill", w * 4, 3'b010, 1'b1, $urandom, 1'b0);

        step("sw10", 32'h10, 3'b010, 1'b1, 32'hDEADBEEF, 1'b0);
        step("lw10", 32'h10, 3'b010, 1'b0, 32'h0, 1'b0);
        check("lw10_const", data_mem_IN, 32'hDEADBEEF);

        step("sb13", 32'h13, 3'b000, 1'b1, 32'h0000_0080, 1'b0);
        step("lb13", 32'h13, 3'b000, 1'b0, 32'h0, 1'b0);
        check("lb13_const", data_mem_IN, 32'hFFFFFF80);
        step("lbu13", 32'h13, 3'b100, 1'b0, 32'h0, 1'b0);
        check("lbu13_const", data_mem_IN, 32'h00000080);
        step("lw10b", 32'h10, 3'b010, 1'b0, 32'h0, 1'b0);
        check("lw10b_const", data_mem_IN, 32'h80ADBEEF);

        step("sh12", 32'h12, 3'b001, 1'b1, 32'hFFFF_1234, 1'b0);
        step("lh12", 32'h12, 3'b001, 1'b0, 32'h0, 1'b0);
        check("lh12_const", data_mem_IN, 32'h00001234);
        step("lhu10", 32'h10, 3'b101, 1'b0, 32'h0, 1'b0);
        check("lhu10_const", data_mem_IN, 32'h0000BEEF);
        step("lw10c", 32'h10, 3'b010, 1'b0, 32'h0, 1'b0);
        check("lw10c_const", data_mem_IN, 32'h1234BEEF);

        step("sw11_bad", 32'h11, 3'b010, 1'b1, 32'h55555555, 1'b0);
        check("sw11_fault", {31'b0, fault}, 32'h1);
        check("sw11_faddr", fault_addrs, 32'h11);
        step("lw10d", 32'h10, 3'b010, 1'b0, 32'h0, 1'b0);
        check("lw10d_const", data_mem_IN, 32'h1234BEEF);
        step("sw1000_oor", 32'h1000, 3'b010, 1'b1, 32'h66666666, 1'b0);
        check("oor_faddr_held", fault_addrs, 32'h11);
        step("clr_sh01", 32'h01, 3'b001, 1'b1, 32'h7777, 1'b1);
        check("clr_set_fault", {31'b0, fault}, 32'h1);
        check("clr_set_faddr", fault_addrs, 32'h01);
        step("clr_only", 32'h0, 3'b000, 1'b0, 32'h0, 1'b1);
        check("clr_fault", {31'b0, fault}, 32'h0);
        step("sbu_bad", 32'h08, 3'b100, 1'b1, 32'h0, 1'b0);
        check("sbu_faddr", fault_addrs, 32'h08);
        step("clr2", 32'h0, 3'b111, 1'b0, 32'h0, 1'b1);
        step("lw_invalid_mode", 32'h10, 3'b011, 1'b0, 32'h0, 1'b0);
        check("invalid_mode_zero", data_mem_IN, 32'h0);

        old_val = ref_load(32'h20, 3'b010);
        step("rdw20", 32'h20, 3'b010, 1'b1, 32'hA5A5A5A5, 1'b0);
        check("rdw20_old", data_mem_IN, old_val);
        step("lw20", 32'h20, 3'b010, 1'b0, 32'h0, 1'b0);
        check("lw20_new", data_mem_IN, 32'hA5A5A5A5);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) == 0) ra = $urandom | 32'h1000;
            else ra = $urandom_range(0, 127);
            step("rand", ra, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom,
                 $urandom_range(0, 9) == 0);
        end

        saved = ref_load(32'h10, 3'b010);
        step("pre_rst_lw", 32'h10, 3'b010, 1'b0, 32'h0, 1'b0);
        step("pre_rst_fault", 32'h11, 3'b010, 1'b1, 32'h0, 1'b0);
        step("pre_rst_lw2", 32'h10, 3'b010, 1'b0, 32'h0, 1'b0);
        #3;
        reset   = 1'b0;
        m_fault = 1'b0;
        m_faddr = 32'h0;
        #1;
        check_zero_outputs("async_rst");
        mem_addrs    = 32'h10;
        mem_MODE     = 3'b010;
        data_mem_OUT = 32'hFFFFFFFF;
        mem_WE       = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check_zero_outputs("in_rst");
        end
        mem_WE = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_zero_outputs("post_rst");
        step("survive", 32'h10, 3'b010, 1'b0, 32'h0, 1'b0);
        check("survive_const", data_mem_IN, saved);

        // Store whose edge finds reset already released is performed.
        reset = 1'b0;
        mem_addrs    = 32'h14;
        mem_MODE     = 3'b010;
        data_mem_OUT = 32'h13572468;
        mem_WE       = 1'b1;
        @(negedge clk);
        #4;
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) mb[32'h14 + i] = data_mem_OUT[8*i +: 8];
        mem_WE = 1'b0;
        step("rel_store", 32'h14, 3'b010, 1'b0, 32'h0, 1'b0);
        check("rel_store_const", data_mem_IN, 32'h13572468);

        // Store whose edge still sees reset low is dropped.
        saved = ref_load(32'h18, 3'b010);
        #2;
        reset = 1'b0;
        mem_addrs    = 32'h18;
        data_mem_OUT = ~saved;
        mem_WE       = 1'b1;
        @(posedge clk);
        #2;
        mem_WE = 1'b0;
        reset  = 1'b1;
        step("held_store", 32'h18, 3'b010, 1'b0, 32'h0, 1'b0);
        check("held_store_const", data_mem_IN, saved);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
